// File: rtl/border_mean_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | border_mean_scheduler                                                    |
// | Post-frame scan of the border accumulator bank: one shared serial        |
// | divider computes sum/count per side x level into a result table.         |
// | Optional: BORDER_MEAN_ROUND_EN selects round-half-up division.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module border_mean_scheduler #(
    parameter int LEVELS = 32,
    parameter int SUM_W  = 32,
    parameter int CNT_W  = 16,
    parameter int PIX_W  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_done,
    output logic [2+$clog2(LEVELS)-1:0]  stat_addr,
    input  logic [SUM_W-1:0]             stat_sum,
    input  logic [CNT_W-1:0]             stat_cnt,
    output logic                         clear_req,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    input  logic [1:0]                   rd_side,
    input  logic [$clog2(LEVELS)-1:0]    rd_level,
    output logic [PIX_W-1:0]             rd_mean
);

    localparam int c_lvl_w  = $clog2(LEVELS);
    localparam int c_addr_w = 2 + c_lvl_w;
    localparam int c_n_ent  = 4 * LEVELS;
`ifdef BORDER_MEAN_ROUND_EN
    localparam int c_div_w  = SUM_W + 1;
`else
    localparam int c_div_w  = SUM_W;
`endif
    localparam int c_bit_w  = $clog2(c_div_w);

    localparam logic [c_addr_w-1:0] c_last_idx = '1;
    localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(c_div_w - 1);
    localparam logic [c_div_w-1:0]  c_pix_max  = c_div_w'({PIX_W{1'b1}});

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_div   = 3'd3;
    localparam logic [2:0] c_st_store = 3'd4;
    localparam logic [2:0] c_st_clear = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    logic [2:0]          r_state;
    logic [c_addr_w-1:0] r_idx;
    logic                r_overrun;
    logic [c_div_w-1:0]  r_quo;
    logic [CNT_W-1:0]    r_rem;
    logic [CNT_W-1:0]    r_div;
    logic [c_bit_w-1:0]  r_bit;
    logic [PIX_W-1:0]    r_rd_mean;
    logic [PIX_W-1:0]    r_table [c_n_ent];

    logic [c_div_w-1:0]  w_dividend;
    logic [CNT_W:0]      w_trial;
    logic [CNT_W:0]      w_diff;
    logic                w_ge;
    logic [PIX_W-1:0]    w_result;

`ifdef BORDER_MEAN_ROUND_EN
    assign w_dividend = {1'b0, stat_sum} + c_div_w'(stat_cnt >> 1);
`else
    assign w_dividend = stat_sum;
`endif

    // Restoring step: the dividend shifts out of r_quo MSB-first while quotient bits shift in.
    assign w_trial  = {r_rem, r_quo[c_div_w-1]};
    assign w_diff   = w_trial - {1'b0, r_div};
    assign w_ge     = (w_trial >= {1'b0, r_div});
    assign w_result = (r_quo > c_pix_max) ? {PIX_W{1'b1}} : r_quo[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
        end else begin
            if (frame_done && (r_state != c_st_idle))
                r_overrun <= 1'b1;
            case (r_state)
                c_st_idle: begin
                    if (frame_done) begin
                        r_idx   <= '0;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_fetch: r_state <= c_st_wait;
                c_st_wait: begin
                    r_div <= stat_cnt;
                    r_rem <= '0;
                    r_bit <= '0;
                    if (stat_cnt == '0) begin
                        r_quo   <= '0;
                        r_state <= c_st_store;
                    end else begin
                        r_quo   <= w_dividend;
                        r_state <= c_st_div;
                    end
                end
                c_st_div: begin
                    r_rem <= CNT_W'(w_ge ? w_diff : w_trial);
                    r_quo <= {r_quo[c_div_w-2:0], w_ge};
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == c_last_bit)
                        r_state <= c_st_store;
                end
                c_st_store: begin
                    if (r_idx == c_last_idx) begin
                        r_state <= c_st_clear;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_clear: r_state <= c_st_done;
                c_st_done:  r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    // Table is deliberately unreset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == c_st_store))
            r_table[r_idx] <= w_result;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_mean <= '0;
        else
            r_rd_mean <= r_table[{rd_side, rd_level}];
    end

    assign stat_addr = r_idx;
    assign busy      = (r_state != c_st_idle);
    assign clear_req = (r_state == c_st_clear);
    assign done      = (r_state == c_st_done);
    assign overrun   = r_overrun;
    assign rd_mean   = r_rd_mean;

endmodule
`default_nettype wire
